// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
// Shared definitions for the bit-serial add/subtract controller.
//   state_e : controller FSM encoding (IDLE waits for a request, RUN streams bits)
//   clog2() : bit-counter width helper, evaluated at elaboration time
package serial_addsub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Ceiling log2, never less than 1 so the counter always has a bit.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >> 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder
// Single-bit full adder cell shared by the serial controller.
//   a_i, b_i, cin_i : addend bits and carry in
//   sum_o           : a ^ b ^ cin
//   cout_o          : majority(a, b, cin)
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl
// Bit-serial add/subtract controller. Operands are latched on an accepted
// start, then one bit pair (LSB first) plus the running carry is pushed
// through a single full_adder per cycle. After WIDTH cycles the result,
// carry out and overflow are published together with a one-cycle done pulse.
//
// Ports
//   clk_i       clock, all state changes on the rising edge
//   rst_i       synchronous active-high reset
//   start_i     request, accepted only while idle (busy_o == 0)
//   sub_i       0: a + b, 1: a - b (sampled with start_i)
//   a_i, b_i    operands (sampled with start_i)
//   busy_o      high while an operation is in progress
//   done_o      one-cycle pulse when result_o/cout_o/overflow_o update
//   result_o    sum/difference modulo 2^WIDTH, held until next completion
//   cout_o      carry out of the MSB (for subtract: 1 = no borrow)
//   overflow_o  signed overflow of the last operation
//
// Configuration
//   SERIAL_ADDSUB_OVF_EN : when defined, overflow_o reports carry-into-MSB
//                          xor carry-out-of-MSB; otherwise it is tied low.
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int             CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    // Only WIDTH-1 sum bits need buffering; the last one comes straight
    // from the adder on the completion edge.
    logic [WIDTH-2:0]   res_sr_q, res_sr_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   sum_shift;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // The shared adder always sees the current LSBs and the carry flop;
    // its outputs only matter while RUN.
    full_adder u_full_adder (
        .a_i    (a_sr_q[0]),
        .b_i    (b_sr_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    assign sum_shift = {fa_sum, res_sr_q};

    // Next-state and datapath control. Subtraction is folded into the
    // accept step: b is inverted and the carry starts at 1, giving ~b + 1.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        done_d   = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d    = ovf_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    a_sr_d  = a_i;
                    b_sr_d  = sub_i ? ~b_i : b_i;
                    carry_d = sub_i;
                    cnt_d   = '0;
                end
            end

            RUN: begin
                res_sr_d = sum_shift[WIDTH-1:1];
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d  = IDLE;
                    result_d = sum_shift;
                    cout_d   = fa_cout;
                    done_d   = 1'b1;
`ifdef SERIAL_ADDSUB_OVF_EN
                    // carry_q is the carry into the MSB on this edge.
                    ovf_d    = carry_q ^ fa_cout;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation and clears every output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            done_q   <= done_d;
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    // Overflow flag, updated only on the completion edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow_o = ovf_q;
`else
    assign overflow_o = 1'b0;
`endif

    assign busy_o   = (state_q == RUN);
    assign done_o   = done_q;
    assign result_o = result_q;
    assign cout_o   = cout_q;

endmodule
